// File: rtl/ahb_dma_pkg.sv
// ahb_dma_pkg: shared DMA constants and the channel arbiter state type
package ahb_dma_pkg;
  localparam int CH_NUM_MAX = 8;
  localparam int PRI_W = 3;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/ahb_dma_pri_enc_sub.sv
// ahb_dma_pri_enc_sub: one-hot priority decode; invalid input decodes as priority 0 (valid, pri -> onehot)
module ahb_dma_pri_enc_sub import ahb_dma_pkg::*; (
  input  logic                  valid,
  input  logic [PRI_W-1:0]      pri,
  output logic [CH_NUM_MAX-1:0] onehot
);
  assign onehot = valid ? CH_NUM_MAX'(1) << pri : CH_NUM_MAX'(1);
endmodule

// File: rtl/ahb_dma_ch_arb.sv
// ahb_dma_ch_arb: max-priority round-robin DMA channel arbiter (HCLK, HRESET, ch_req/ch_pri/ch_done/arb_pause -> gnt_valid/gnt_ch/gnt_pri)
module ahb_dma_ch_arb import ahb_dma_pkg::*; #(
  parameter int CH_NUM = 8,
  parameter int PRI_W = 3
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [CH_NUM-1:0]             ch_req,
  input  logic [CH_NUM-1:0][PRI_W-1:0]  ch_pri,
  input  logic                          ch_done,
  input  logic                          arb_pause,
  output logic                          gnt_valid,
  output logic [2:0]                    gnt_ch,
  output logic [PRI_W-1:0]              gnt_pri
);
  localparam int IW = $clog2(CH_NUM);
  arb_state_t state, state_n;
  logic [2:0] last_gnt, last_gnt_n, gnt_ch_n, sel;
  logic [PRI_W-1:0] gnt_pri_n, max_pri;
  logic gnt_valid_n;
  logic [CH_NUM-1:0][CH_NUM_MAX-1:0] onehot;
  logic [CH_NUM_MAX-1:0] pri_or;
  logic [CH_NUM-1:0] cand;
  function automatic logic [PRI_W-1:0] max_pri_f(input logic [CH_NUM_MAX-1:0] v);
    logic [PRI_W-1:0] r;
    r = '0;
    for (int i = 0; i < CH_NUM_MAX; i++) if (v[i]) r = PRI_W'(i);
    return r;
  endfunction
  function automatic logic [2:0] rr_f(input logic [CH_NUM-1:0] c, input logic [2:0] last);
    logic [2:0] r;
    int idx;
    r = '0;
    for (int k = CH_NUM; k >= 1; k--) begin
      idx = (int'(last) + k) % CH_NUM;
      if (c[idx]) r = 3'(idx);
    end
    return r;
  endfunction
  for (genvar i = 0; i < CH_NUM; i++) begin : g_enc
    ahb_dma_pri_enc_sub u_enc (.valid(ch_req[i]), .pri(ch_pri[i]), .onehot(onehot[i]));
  end
  always_comb begin
    pri_or = '0;
    cand = '0;
    for (int c = 0; c < CH_NUM; c++) pri_or |= onehot[c];
    for (int c = 0; c < CH_NUM; c++) cand[c] = ch_req[c] && ch_pri[c] == max_pri;
  end
  assign max_pri = max_pri_f(pri_or);
  assign sel = rr_f(cand, last_gnt);
  always_comb begin
    state_n = state;
    gnt_valid_n = gnt_valid;
    gnt_ch_n = gnt_ch;
    gnt_pri_n = gnt_pri;
    last_gnt_n = last_gnt;
    if (state == IDLE && |ch_req && !arb_pause) begin
      state_n = GRANT;
      gnt_valid_n = 1'b1;
      gnt_ch_n = sel;
      gnt_pri_n = max_pri;
    end else if (state == GRANT && (ch_done || !ch_req[gnt_ch[IW-1:0]])) begin
      state_n = IDLE;
      gnt_valid_n = 1'b0;
      last_gnt_n = ch_done ? gnt_ch : last_gnt;
    end
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
      gnt_valid <= 1'b0;
      gnt_ch <= '0;
      gnt_pri <= '0;
      last_gnt <= 3'(CH_NUM - 1);
    end else begin
      state <= state_n;
      gnt_valid <= gnt_valid_n;
      gnt_ch <= gnt_ch_n;
      gnt_pri <= gnt_pri_n;
      last_gnt <= last_gnt_n;
    end
  end
endmodule

// File: tb/tb_ahb_dma_ch_arb.sv
// tb_ahb_dma_ch_arb: scoreboard bench for the DMA channel arbiter
module tb_ahb_dma_ch_arb;
  logic HCLK = 1'b0;
  logic HRESET, ch_done, arb_pause, gnt_valid;
  logic [7:0] ch_req;
  logic [7:0][2:0] ch_pri;
  logic [2:0] gnt_ch, gnt_pri;
  logic [5:0] sb[$];
  logic [5:0] cur_exp;
  logic prev_v = 1'b0;
  int checks = 0;
  int failures = 0;
  ahb_dma_ch_arb #(.CH_NUM(8), .PRI_W(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .ch_req(ch_req), .ch_pri(ch_pri), .ch_done(ch_done),
    .arb_pause(arb_pause), .gnt_valid(gnt_valid), .gnt_ch(gnt_ch), .gnt_pri(gnt_pri)
  );
  always #5 HCLK = ~HCLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge HCLK);
    #1;
  endtask
  task automatic done(input logic [7:0] req_after);
    ch_done = 1'b1;
    ch_req = req_after;
    tick();
    ch_done = 1'b0;
    chk("done_drop", gnt_valid, 0);
  endtask
  always @(negedge HCLK) begin
    if (gnt_valid === 1'b1 && !prev_v) begin
      if (sb.size() == 0) chk("unexpected_grant", 1, 0);
      else begin
        cur_exp = sb.pop_front();
        chk("gnt_ch", gnt_ch, cur_exp[5:3]);
        chk("gnt_pri", gnt_pri, cur_exp[2:0]);
      end
    end else if (gnt_valid === 1'b1) begin
      chk("hold_ch", gnt_ch, cur_exp[5:3]);
      chk("hold_pri", gnt_pri, cur_exp[2:0]);
    end
    prev_v = (gnt_valid === 1'b1);
  end
  initial begin
    HRESET = 1'b1; ch_req = '0; ch_pri = '0; ch_done = 1'b0; arb_pause = 1'b0;
    tick(2);
    chk("rst_valid", gnt_valid, 0);
    chk("rst_ch", gnt_ch, 0);
    chk("rst_pri", gnt_pri, 0);
    HRESET = 1'b0;
    // single request, 1-cycle latency
    ch_pri[2] = 3'd5; ch_req = 8'h04; sb.push_back({3'd2, 3'd5});
    tick();
    chk("single_lat", gnt_valid, 1);
    done(8'h00);
    // highest priority wins, then lower after an idle cycle
    ch_pri[0] = 3'd2; ch_pri[7] = 3'd6; ch_req = 8'h81;
    sb.push_back({3'd7, 3'd6}); sb.push_back({3'd0, 3'd2});
    tick();
    chk("pri_v", gnt_valid, 1);
    done(8'h01);
    tick();
    chk("pri_v2", gnt_valid, 1);
    done(8'h00);
    // round robin at equal priority, one idle cycle between grants
    ch_pri[1] = 3'd4; ch_pri[3] = 3'd4; ch_pri[5] = 3'd4; ch_req = 8'h2A;
    sb.push_back({3'd1, 3'd4}); sb.push_back({3'd3, 3'd4});
    sb.push_back({3'd5, 3'd4}); sb.push_back({3'd1, 3'd4});
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_v", gnt_valid, 1);
      done(k == 3 ? 8'h00 : 8'h2A);
    end
    // withdrawal does not advance last_gnt
    ch_pri[3] = 3'd1; ch_req = 8'h08; sb.push_back({3'd3, 3'd1});
    tick();
    chk("wd_v", gnt_valid, 1);
    ch_req = 8'h00;
    tick();
    chk("wd_drop", gnt_valid, 0);
    ch_pri[3] = 3'd2; ch_pri[6] = 3'd2; ch_req = 8'h48; sb.push_back({3'd3, 3'd2});
    tick();
    chk("wd_tie_v", gnt_valid, 1);
    done(8'h00);
    // pause blocks grants, done in idle ignored
    arb_pause = 1'b1; ch_req = 8'hFF; ch_done = 1'b1;
    tick();
    ch_done = 1'b0;
    tick(2);
    chk("pause_v", gnt_valid, 0);
    chk("pause_ch", gnt_ch, 3);
    chk("pause_pri", gnt_pri, 2);
    ch_pri[4] = 3'd7; arb_pause = 1'b0; sb.push_back({3'd4, 3'd7});
    tick();
    chk("unpause_v", gnt_valid, 1);
    // reset mid-grant wins over live requests and restores last_gnt
    HRESET = 1'b1;
    tick();
    chk("rst2_v", gnt_valid, 0);
    chk("rst2_ch", gnt_ch, 0);
    chk("rst2_pri", gnt_pri, 0);
    HRESET = 1'b0; ch_pri = '0; ch_pri[0] = 3'd3; ch_pri[5] = 3'd3; ch_req = 8'h21;
    sb.push_back({3'd0, 3'd3});
    tick();
    chk("rst_tie_v", gnt_valid, 1);
    done(8'h00);
    // grant holds while a higher priority arrives
    ch_pri[2] = 3'd1; ch_req = 8'h04; sb.push_back({3'd2, 3'd1});
    tick();
    ch_pri[6] = 3'd7; ch_req = 8'h44;
    tick(3);
    chk("stable_ch", gnt_ch, 2);
    sb.push_back({3'd6, 3'd7});
    done(8'h40);
    tick();
    chk("stable_next_v", gnt_valid, 1);
    done(8'h00);
    // priority 0 is a real request
    ch_pri[1] = 3'd0; ch_req = 8'h02; sb.push_back({3'd1, 3'd0});
    tick();
    chk("pri0_v", gnt_valid, 1);
    done(8'h00);
    tick(2);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_dma_ch_arb.md
AHB_DMA_CH_ARB -- requirements
Module: ahb_dma_ch_arb

Interface
REQ-001 Parameter CH_NUM, default 8, number of DMA channels arbitrated; legal range 2..8.
REQ-002 Parameter PRI_W, default 3, channel priority width; fixed at 3, giving priority levels 0..7 with 7 highest.
REQ-003 HCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 HRESET  input  1  synchronous, active-high reset.
REQ-005 ch_req  input  CH_NUM  per-channel transfer request, level-sensitive.
REQ-006 ch_pri  input  CH_NUM x 3  per-channel priority, sampled only in cycles where that channel's ch_req is high.
REQ-007 ch_done  input  1  single-cycle pulse from the transfer engine: the granted transfer has completed.
REQ-008 arb_pause  input  1  blocks new grants without affecting a grant already held.
REQ-009 gnt_valid  output  1  a channel is currently granted.
REQ-010 gnt_ch  output  3  index of the granted channel.
REQ-011 gnt_pri  output  3  priority of the granted channel, captured at grant time.

Function
REQ-012 The FSM shall have exactly two states: IDLE and GRANT.
REQ-013 Per-channel priority shall be decoded one-hot: valid channel -> 8'b1 << pri; invalid channel -> 8'b1, i.e. decoded as priority 0.
REQ-014 The one-hot vectors of all channels shall be ORed, and the highest set bit shall give max_pri.
REQ-015 Candidate set = channels with ch_req=1 and ch_pri==max_pri.
REQ-016 Among candidates, the selected channel shall be the first index strictly greater than last_gnt, searching upward with wrap from CH_NUM-1 to 0.
REQ-017 IDLE to GRANT: when |ch_req=1 and arb_pause=0, the block shall register gnt_ch, gnt_pri and gnt_valid=1 on the next edge, i.e. grant latency is 1 cycle from request.
REQ-018 In GRANT, gnt_ch, gnt_pri and gnt_valid shall hold stable regardless of other ch_req, ch_pri or arb_pause changes.
REQ-019 GRANT to IDLE on ch_done=1: the block shall set last_gnt<=gnt_ch and gnt_valid<=0.
REQ-020 GRANT to IDLE on withdrawal, i.e. ch_req[gnt_ch]=0 with ch_done=0: the block shall set gnt_valid<=0 and leave last_gnt unchanged.
REQ-021 If ch_done and withdrawal occur in the same cycle, the block shall treat the event as ch_done.
REQ-022 The block shall spend at least one IDLE cycle (gnt_valid=0) between consecutive grants, including back-to-back requests.
REQ-023 ch_done received in IDLE shall be ignored.
REQ-024 arb_pause=1 in IDLE shall keep the FSM in IDLE with all outputs unchanged.
REQ-025 Priority 0 with ch_req=1 is a valid request and shall be grantable when no higher priority is present.
REQ-026 A channel index >= CH_NUM shall never appear on gnt_ch.

Reset
REQ-027 HRESET=1 shall force state=IDLE, gnt_valid=0, gnt_ch=0, gnt_pri=0 and last_gnt=CH_NUM-1, so that channel 0 wins the first tie.
REQ-028 HRESET asserted during GRANT shall drop gnt_valid on the next edge; no done is implied and no state is retained.
REQ-029 HRESET shall take precedence over every other input in the same cycle.

Structure
REQ-030 Shared package ahb_dma_pkg shall hold CH_NUM_MAX=8, PRI_W=3, and typedef arb_state_t {IDLE, GRANT}.
REQ-031 The one-hot decode shall reuse ahb_dma_pri_enc_sub, one instance per channel; no new sub-module shall be created.
REQ-032 The max-priority search and round-robin search shall be combinational functions local to this module, and all outputs shall be registered.

Verification
REQ-033 Single request: ch_req=8'h04, pri[2]=5 -> after 1 cycle gnt_valid=1, gnt_ch=2, gnt_pri=5; ch_done pulse -> gnt_valid=0 next cycle.
REQ-034 Priority: ch_req=8'h81, pri[0]=2, pri[7]=6 -> gnt_ch=7; after done with ch7 dropped -> gnt_ch=0 after one idle cycle.
REQ-035 Round-robin: ch1, ch3 and ch5 held at priority 4, done on every grant -> grant order 1,3,5,1, with a 1-cycle gap between each grant.
REQ-036 Withdrawal: grant ch3, then drop ch_req[3] -> gnt_valid=0 next cycle, last_gnt unchanged, and a tie between ch3 and ch6 then picks ch3.
REQ-037 Pause/reset: arb_pause=1 with ch_req=8'hFF -> no grant; HRESET during grant of ch4 -> gnt_valid=0 and last_gnt=7 afterwards, so the next tie at equal priority picks ch0.
REQ-038 Stability: during a grant of ch2, raise ch6 at priority 7 -> gnt_ch remains 2 until ch_done.
